// File: rtl/video_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// video_pattern_gen_if : control/position inputs and video outputs of the
//                        note-box pattern generator.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface video_pattern_gen_if;
  logic        Enable;
  logic [4:0]  NoteOn;
  logic [23:0] GreenPos;
  logic [23:0] RedPos;
  logic [23:0] YellowPos;
  logic [23:0] BluePos;
  logic [23:0] OrangePos;
  logic [23:0] NoteColour;
  logic [23:0] IdleColour;
  logic [23:0] BackColour;
  logic        HSync;
  logic        VSync;
  logic        VDE;
  logic [23:0] RGB;
  logic        FrameStart;
  logic [15:0] FrameCount;

  modport master (
    output Enable, NoteOn, GreenPos, RedPos, YellowPos, BluePos, OrangePos,
           NoteColour, IdleColour, BackColour,
    input  HSync, VSync, VDE, RGB, FrameStart, FrameCount
  );

  modport slave (
    input  Enable, NoteOn, GreenPos, RedPos, YellowPos, BluePos, OrangePos,
           NoteColour, IdleColour, BackColour,
    output HSync, VSync, VDE, RGB, FrameStart, FrameCount
  );
endinterface

`default_nettype wire

// File: rtl/video_pattern_gen.sv
// ----------------------------------------------------------------------------
// video_pattern_gen : raster timing generator drawing five note boxes over a
//                     background colour.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOX      = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  video_pattern_gen_if.slave bus
);

  localparam logic [11:0] C_H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] C_H_SYNC0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] C_H_SYNC1 = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] C_H_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] C_V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] C_V_SYNC0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] C_V_SYNC1 = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] C_V_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] C_BOX_M1  = 12'(BOX - 1);

  logic [11:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [4:0]        note_on_q, note_on_d;
  logic [4:0][10:0]  pos_x_q, pos_x_d;
  logic [4:0][9:0]   pos_y_q, pos_y_d;
  logic [23:0]       note_col_q, note_col_d, idle_col_q, idle_col_d;
  logic [23:0]       back_col_q, back_col_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d;
  logic              fstart_q, fstart_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [15:0]       fcount_q, fcount_d;

  logic              w_origin, w_line_end, w_frame_end, w_active, w_found;
  logic [4:0]        w_note_on;
  logic [4:0][23:0]  w_pos_in;
  logic [4:0][10:0]  w_pos_x;
  logic [4:0][9:0]   w_pos_y;
  logic [23:0]       w_note_col, w_idle_col, w_back_col, w_pix;
  logic [11:0]       w_x, w_y;
  logic              w_unused_pos_bits;

  assign w_pos_in = {bus.OrangePos, bus.BluePos, bus.YellowPos,
                     bus.RedPos, bus.GreenPos};

  assign w_unused_pos_bits = ^{bus.GreenPos[23:22], bus.GreenPos[11],
                               bus.RedPos[23:22], bus.RedPos[11],
                               bus.YellowPos[23:22], bus.YellowPos[11],
                               bus.BluePos[23:22], bus.BluePos[11],
                               bus.OrangePos[23:22], bus.OrangePos[11]};

  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    note_on_d   = note_on_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    note_col_d  = note_col_q;
    idle_col_d  = idle_col_q;
    back_col_d  = back_col_q;
    w_pix       = '0;
    w_found     = 1'b0;
    w_x         = '0;
    w_y         = '0;

    w_origin    = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    w_line_end  = (h_cnt_q == C_H_LAST);
    w_frame_end = w_line_end && (v_cnt_q == C_V_LAST);
    w_active    = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);

    if (!bus.Enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (w_line_end) begin
      h_cnt_d = '0;
      v_cnt_d = w_frame_end ? 12'd0 : v_cnt_q + 12'd1;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end

    if (bus.Enable && w_frame_end)
      frame_cnt_d = frame_cnt_q + 16'd1;

    for (int f = 0; f < 5; f++) begin
      w_pos_x[f] = w_pos_in[f][10:0];
      w_pos_y[f] = w_pos_in[f][21:12];
    end

    // The first pixel of a frame is drawn from the values being latched on
    // that same edge, so the whole frame uses one consistent snapshot.
    if (bus.Enable && w_origin) begin
      note_on_d  = bus.NoteOn;
      pos_x_d    = w_pos_x;
      pos_y_d    = w_pos_y;
      note_col_d = bus.NoteColour;
      idle_col_d = bus.IdleColour;
      back_col_d = bus.BackColour;
    end else begin
      w_pos_x    = pos_x_q;
      w_pos_y    = pos_y_q;
    end
    w_note_on  = note_on_d;
    w_note_col = note_col_d;
    w_idle_col = idle_col_d;
    w_back_col = back_col_d;

    // Index 0 (green) is tested first, so it wins any overlap.
    w_pix = w_back_col;
    for (int f = 0; f < 5; f++) begin
      w_x = {1'b0, w_pos_x[f]};
      w_y = {2'b00, w_pos_y[f]};
      if (!w_found &&
          (h_cnt_q >= w_x) && (h_cnt_q <= w_x + C_BOX_M1) &&
          (v_cnt_q >= w_y) && (v_cnt_q <= w_y + C_BOX_M1)) begin
        w_found = 1'b1;
        w_pix   = w_note_on[f] ? w_note_col : w_idle_col;
      end
    end

    hsync_d  = bus.Enable && (h_cnt_q >= C_H_SYNC0) && (h_cnt_q <= C_H_SYNC1);
    vsync_d  = bus.Enable && (v_cnt_q >= C_V_SYNC0) && (v_cnt_q <= C_V_SYNC1);
    vde_d    = bus.Enable && w_active;
    fstart_d = bus.Enable && w_origin;
    rgb_d    = (bus.Enable && w_active) ? w_pix : 24'd0;
    // The frame counter updates while the counters sit at (0,0); this copy
    // delays it so it changes together with FrameStart.
    fcount_d = frame_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      note_on_q   <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      note_col_q  <= '0;
      idle_col_q  <= '0;
      back_col_q  <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      vde_q       <= 1'b0;
      fstart_q    <= 1'b0;
      rgb_q       <= '0;
      fcount_q    <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      note_on_q   <= note_on_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      note_col_q  <= note_col_d;
      idle_col_q  <= idle_col_d;
      back_col_q  <= back_col_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      vde_q       <= vde_d;
      fstart_q    <= fstart_d;
      rgb_q       <= rgb_d;
      fcount_q    <= fcount_d;
    end
  end

  assign bus.HSync      = hsync_q;
  assign bus.VSync      = vsync_q;
  assign bus.VDE        = vde_q;
  assign bus.RGB        = rgb_q;
  assign bus.FrameStart = fstart_q;
  assign bus.FrameCount = fcount_q;

endmodule

`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_video_pattern_gen : directed bench for video_pattern_gen on a reduced
//                        24x15 raster (360 cycles per frame).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_video_pattern_gen;
  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 10, V_FP = 2, V_SYNC = 2, V_BP = 1;
  localparam int BOX = 4;
  localparam logic [23:0] NOTE = 24'h11AA22;
  localparam logic [23:0] IDLE = 24'h333333;
  localparam logic [23:0] BACK = 24'h0000C0;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  video_pattern_gen_if bus ();

  video_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BOX(BOX)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [23:0] pos(input int x, input int y);
    return 24'((y << 12) | x);
  endfunction

  // After a tick, outputs describe raster position cyc-1.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic go(input int p);
    while (cyc < p + 1) tick();
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST            = 1'b0;
    bus.Enable     = 1'b0;
    bus.NoteOn     = 5'b00001;
    bus.GreenPos   = pos(5, 3);
    bus.RedPos     = pos(2000, 0);
    bus.YellowPos  = pos(2000, 0);
    bus.BluePos    = pos(2000, 0);
    bus.OrangePos  = pos(2000, 0);
    bus.NoteColour = NOTE;
    bus.IdleColour = IDLE;
    bus.BackColour = BACK;
    repeat (3) tick();
    chk("rst_vde", 24'(bus.VDE), 24'd0);
    chk("rst_hsync", 24'(bus.HSync), 24'd0);
    chk("rst_rgb", bus.RGB, 24'd0);
    chk("rst_fcount", 24'(bus.FrameCount), 24'd0);

    // Frame 0
    RST = 1'b1; bus.Enable = 1'b1; cyc = 0;
    go(0);
    chk("f0_start", 24'(bus.FrameStart), 24'd1);
    chk("f0_vde0", 24'(bus.VDE), 24'd1);
    chk("f0_rgb0", bus.RGB, BACK);
    go(1);
    chk("f0_start_end", 24'(bus.FrameStart), 24'd0);
    go(15);
    chk("vde_last_px", 24'(bus.VDE), 24'd1);
    go(16);
    chk("vde_h16", 24'(bus.VDE), 24'd0);
    chk("rgb_blank", bus.RGB, 24'd0);
    go(17);
    chk("hs_h17", 24'(bus.HSync), 24'd0);
    go(18);
    chk("hs_h18", 24'(bus.HSync), 24'd1);
    go(20);
    chk("hs_h20", 24'(bus.HSync), 24'd1);
    go(21);
    chk("hs_h21", 24'(bus.HSync), 24'd0);

    // Mid-frame edits: not visible until frame 1
    bus.NoteOn = 5'b00010;
    bus.RedPos = pos(5, 3);
    go(76);  chk("box_4_3", bus.RGB, BACK);
    go(77);  chk("box_5_3", bus.RGB, NOTE);
    go(80);  chk("box_8_3", bus.RGB, NOTE);
    go(81);  chk("box_9_3", bus.RGB, BACK);
    go(101); chk("box_5_4_old", bus.RGB, NOTE);
    go(149); chk("box_5_6", bus.RGB, NOTE);
    go(173); chk("box_5_7", bus.RGB, BACK);
    go(240); chk("vde_v10", 24'(bus.VDE), 24'd0);
    go(287); chk("vs_v11", 24'(bus.VSync), 24'd0);
    go(288); chk("vs_v12", 24'(bus.VSync), 24'd1);
    go(335); chk("vs_v13_end", 24'(bus.VSync), 24'd1);
    go(336); chk("vs_v14", 24'(bus.VSync), 24'd0);
    go(359); chk("fcount_f0_end", 24'(bus.FrameCount), 24'd0);

    // Frame 1
    go(360);
    chk("fcount_1", 24'(bus.FrameCount), 24'd1);
    chk("f1_start", 24'(bus.FrameStart), 24'd1);
    go(462); chk("overlap_idle", bus.RGB, IDLE);
    bus.NoteOn = 5'b00001;
    go(487); chk("overlap_hold", bus.RGB, IDLE);

    // Frame 2
    go(720); chk("fcount_2", 24'(bus.FrameCount), 24'd2);
    go(847); chk("overlap_note", bus.RGB, NOTE);

    // Reset at line 5, h=10
    go(849);
    RST = 1'b0;
    tick();
    chk("mrst_vde", 24'(bus.VDE), 24'd0);
    chk("mrst_rgb", bus.RGB, 24'd0);
    chk("mrst_fcount", 24'(bus.FrameCount), 24'd0);
    RST = 1'b1; cyc = 0;
    go(0);
    chk("mrst_restart", 24'(bus.FrameStart), 24'd1);
    chk("mrst_rgb0", bus.RGB, BACK);
    go(77); chk("mrst_box", bus.RGB, NOTE);

    // Enable drop at line 4, h=10
    go(105);
    bus.Enable = 1'b0;
    tick();
    chk("dis_vde", 24'(bus.VDE), 24'd0);
    chk("dis_rgb", bus.RGB, 24'd0);
    repeat (30) tick();
    chk("dis_hsync", 24'(bus.HSync), 24'd0);
    chk("dis_fcount", 24'(bus.FrameCount), 24'd0);
    bus.Enable = 1'b1;
    tick();
    chk("en_fstart", 24'(bus.FrameStart), 24'd1);
    chk("en_vde", 24'(bus.VDE), 24'd1);
    tick();
    chk("en_fstart_end", 24'(bus.FrameStart), 24'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  H_ACTIVE, 640, active pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, HSync pulse width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, active lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, VSync pulse width (lines)
  V_BP, 33, vertical back porch (lines)
  BOX, 8, note box edge length (pixels, 1..64)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  CLK  in  1  pixel clock; sole clock
  RST  in  1  synchronous active-low reset
  Enable  in  1  1 = generate video, 0 = hold idle
  NoteOn  in  5  {O,B,Y,R,G} lit-note request
  GreenPos/RedPos/YellowPos/BluePos/OrangePos  in  24 each  box top-left: x=[10:0], y=[21:12], other bits ignored
  NoteColour  in  24  RGB of a lit box
  IdleColour  in  24  RGB of an unlit box
  BackColour  in  24  RGB of active pixels outside boxes
  HSync  out  1  horizontal sync, active-high
  VSync  out  1  vertical sync, active-high
  VDE  out  1  active video
  RGB  out  24  pixel data
  FrameStart  out  1  one-cycle pulse on first active pixel of frame
  FrameCount  out  16  completed-frame counter
REQ-003 The block SHALL use one clock, CLK; reset RST SHALL be synchronous and active-low.

Function
REQ-004 hCnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, 800 default), wrapping to 0 and advancing vCnt; vCnt SHALL count 0..V_TOTAL-1 (525 default), wrapping to 0.
REQ-005 Active region SHALL be hCnt<H_ACTIVE and vCnt<V_ACTIVE.
REQ-006 HSync SHALL be high for hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] on every line.
REQ-007 VSync SHALL be high for entire lines vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], changing at hCnt=0.
REQ-008 All outputs SHALL be registered; outputs at cycle t+1 reflect counters/inputs at cycle t (latency 1), all outputs mutually aligned.
REQ-009 NoteOn, all five Pos inputs and all three colours SHALL be latched when hCnt=0 and vCnt=0; mid-frame changes SHALL take effect next frame only.
REQ-010 Box hit for fret f: x_f <= hCnt <= x_f+BOX-1 and y_f <= vCnt <= y_f+BOX-1, compared at 12 bits so x+BOX never wraps; boxes extending past active area are clipped.
REQ-011 Active pixel RGB: highest-priority hitting fret (Green > Red > Yellow > Blue > Orange) gives NoteColour if its latched NoteOn bit is 1, else IdleColour; no hit gives BackColour.
REQ-012 RGB SHALL be 0 whenever VDE=0.
REQ-013 FrameStart SHALL pulse for the cycle VDE first rises at (0,0); FrameCount SHALL increment by 1 on each vCnt/hCnt wrap to (0,0), wrapping 0xFFFF->0.
REQ-014 Enable=0 SHALL hold hCnt=vCnt=0 and drive HSync=VSync=VDE=FrameStart=0, RGB=0, FrameCount held; Enable rising SHALL start a fresh frame at (0,0) next cycle.

Reset
REQ-015 RST=0 at a CLK edge SHALL clear hCnt, vCnt, FrameCount, latched notes/positions/colours and all outputs to 0 on that edge, regardless of position in frame.
REQ-016 First cycle with RST=1 and Enable=1 SHALL be hCnt=0,vCnt=0, so VDE=1 and FrameStart=1 appear one cycle later.

Verification
REQ-017 Reset release, Enable=1, defaults -> HSync rises 657 cycles after first enabled cycle, stays high 96 cycles, period 800.
REQ-018 Free-run -> VSync high for exactly 1600 cycles starting line 490; VDE high 640 cycles/line on lines 0..479; FrameCount=1 after 420000 cycles.
REQ-019 NoteOn=5'b00001, GreenPos x=100,y=50, other boxes off-screen at x=2000 -> pixels (100..107,50..57)=NoteColour; (99,50) and (108,50) = BackColour.
REQ-020 Green and Red at same position, NoteOn=5'b00010 -> overlap pixels = IdleColour (Green priority); NoteOn changed mid-frame -> no change until next frame.
REQ-021 RST=0 for one cycle at line 100, hCnt=300 -> all outputs 0 next cycle, FrameCount=0, frame restarts at (0,0).
REQ-022 Enable=0 mid-line -> syncs, VDE, RGB 0 next cycle; Enable=1 -> FrameStart pulse 1 cycle later.
